// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD A-B, one digit per cycle LSD first; DIGITS cycles from accepted start to a one-cycle done pulse.
// start is only honoured while not busy; diff/borrow_out/invalid hold until the next operation's final edge.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow_out,
    output logic                  invalid
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] a_q, b_q, acc_q, acc_d, diff_q;
    logic [CW-1:0]       cnt_q;
    logic                borrow_q, borrow_d, inv_q;
    logic                busy_q, done_q, borrow_out_q, invalid_q;
    logic [3:0]          a_dig, b_dig, dig_d;
    logic [4:0]          t;
    logic                start_inv;

    always_comb begin
        a_dig     = '0;
        b_dig     = '0;
        start_inv = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_q[i*4 +: 4];
                b_dig = b_q[i*4 +: 4];
            end
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9)
                start_inv = 1'b1;
        end
        // 5-bit two's complement: bit 4 set means the digit went negative
        t        = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, borrow_q};
        borrow_d = t[4];
        dig_d    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        acc_d    = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i))
                acc_d[i*4 +: 4] = dig_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            inv_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        borrow_q <= 1'b0;
                        inv_q    <= start_inv;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        diff_q       <= inv_q ? '0 : acc_d;
                        borrow_out_q <= inv_q ? 1'b0 : borrow_d;
                        invalid_q    <= inv_q;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign invalid    = invalid_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor: integer-arithmetic reference model, randomized operands.
module tb_bcd_serial_subtractor;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bo;
        logic         inv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow_out, invalid;
    logic [W-1:0] diff;

    int   checks   = 0;
    int   failures = 0;
    exp_t expq[$];
    exp_t mon_e;
    exp_t pending;
    exp_t last_e;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .borrow_out(borrow_out), .invalid(invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb);
        exp_t       e;
        int         av, bv, scale, d;
        bit         bad;
        logic [3:0] da, db;
        av = 0; bv = 0; scale = 1; bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            da = aa[i*4 +: 4];
            db = bb[i*4 +: 4];
            if (da > 4'd9 || db > 4'd9) bad = 1'b1;
            av += int'(da) * scale;
            bv += int'(db) * scale;
            scale *= 10;
        end
        e = '0;
        if (bad) begin
            e.inv = 1'b1;
            return e;
        end
        d = av - bv;
        if (d < 0) begin
            d += scale;
            e.bo = 1'b1;
        end
        for (int i = 0; i < DIGITS; i++) begin
            e.diff[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 19) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else                           v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 diff=%0h", diff);
            end else begin
                mon_e = expq.pop_front();
                check("diff", 32'(diff), 32'(mon_e.diff));
                check("borrow_out", 32'(borrow_out), 32'(mon_e.bo));
                check("invalid", 32'(invalid), 32'(mon_e.inv));
            end
        end
    end

    // Called at a negedge where the DUT can accept; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit expect_result);
        a = aa; b = bb; start = 1'b1;
        pending = model(aa, bb);
        if (expect_result) expq.push_back(pending);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("done_low_after_accept", 32'(done), 32'd0);
    endtask

    // Returns in the done cycle. junk=1 drives ignored starts while busy.
    task automatic wait_done(input bit junk);
        int cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            check("busy_while_running", 32'(busy), 32'd1);
            check("diff_held_while_running", 32'(diff), 32'(last_e.diff));
            if (junk) begin
                a = rand_bcd(); b = rand_bcd(); start = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("latency", 32'(cycles), 32'(DIGITS));
        check("busy_low_in_done", 32'(busy), 32'd0);
        last_e = pending;
    endtask

    task automatic step_idle();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("diff_held_idle", 32'(diff), 32'(last_e.diff));
    endtask

    logic [W-1:0] dir_a[7] = '{16'h0042, 16'h0017, 16'h1000, 16'h5555, 16'h0000, 16'h00A3, 16'h0042};
    logic [W-1:0] dir_b[7] = '{16'h0017, 16'h0042, 16'h0001, 16'h5555, 16'h0001, 16'h0001, 16'h0017};

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        last_e = '0; pending = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow_out", 32'(borrow_out), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(dir_a[i], dir_b[i], 1'b1);
            wait_done(1'b0);
            step_idle();
        end

        // Starts during busy are ignored
        issue(16'h0042, 16'h0017, 1'b1);
        wait_done(1'b1);
        step_idle();

        // Back-to-back: start in the done cycle
        issue(16'h0042, 16'h0017, 1'b1);
        wait_done(1'b0);
        issue(16'h0100, 16'h0001, 1'b1);
        wait_done(1'b0);
        step_idle();

        for (int n = 0; n < 60; n++) begin
            issue(rand_bcd(), rand_bcd(), 1'b1);
            wait_done(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) step_idle();
        end
        if (done === 1'b1) step_idle();

        // Abort mid-operation: rst at E2, no done pulse
        issue(16'h0017, 16'h0042, 1'b1);
        wait_done(1'b0);
        step_idle();
        issue(16'h0042, 16'h0017, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_e = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow_out", 32'(borrow_out), 32'd0);
        check("abort_invalid", 32'(invalid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        issue(16'h0042, 16'h0017, 1'b1);
        wait_done(1'b0);
        step_idle();

        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
